// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: wb source selects and load funct3 codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Contents:
//   XLEN/RADDR_W/CNT_W  default datapath, register-address and counter widths
//   WB_SEL_*            writeback source select encodings (3 is reserved, treated as ALU)
//   F3_*                RV32I load funct3 encodings
package wb_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int CNT_W_DEF   = 64;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data extraction: picks the byte/halfword addressed by the low address bits and extends it.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   word_i    [XLEN-1:0]  raw aligned word read from dmem
//   off_i     [1:0]       byte offset within the word (load address bits [1:0])
//   funct3_i  [2:0]       load size/sign; unknown codes behave as LW
//   result_o  [XLEN-1:0]  extended load value
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    half_sel = word_i[15:0];
    result_o = word_i;

    case (off_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase

    // Halfword lane comes from off[1] only; a misaligned off[0] is ignored.
    if (off_i[1]) begin
      half_sel = word_i[31:16];
    end

    case (funct3_i)
      F3_LB:   result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: M->W pipeline register, load extraction, wb source mux, regfile write port,
// W->D bypass and retired-instruction counter.
// Latency: outputs are combinational from the W register (instr visible the cycle after it is in M).
// Backpressure: stall holds W (and freezes the load word); flush inserts a bubble and wins over stall.
//
// Ports:
//   clk, reset                          rising-edge clock, synchronous active-high reset
//   stall, flush                        hold W / replace incoming M instr with a bubble
//   m_valid, m_reg_we, m_rd, m_wb_sel,
//   m_funct3, m_alu_result, m_pc        M-stage instruction fields
//   dmem_rdata                          dmem word, valid only in the first cycle an instr is in W
//   rf_we, rf_wb_addr, rf_wb_data       regfile write port
//   fwd_valid, fwd_rd, fwd_data         W->D bypass (same as the write port)
//   instret                             retired-instruction count
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               m_valid,
  input  logic               m_reg_we,
  input  logic [RADDR_W-1:0] m_rd,
  input  logic [1:0]         m_wb_sel,
  input  logic [2:0]         m_funct3,
  input  logic [XLEN-1:0]    m_alu_result,
  input  logic [XLEN-1:0]    m_pc,
  input  logic [XLEN-1:0]    dmem_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_wb_addr,
  output logic [XLEN-1:0]    rf_wb_data,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic [CNT_W-1:0]   instret
);

  // W pipeline register
  logic               w_valid_q,  w_valid_d;
  logic               w_reg_we_q, w_reg_we_d;
  logic [RADDR_W-1:0] w_rd_q,     w_rd_d;
  logic [1:0]         w_wb_sel_q, w_wb_sel_d;
  logic [2:0]         w_funct3_q, w_funct3_d;
  logic [XLEN-1:0]    w_alu_q,    w_alu_d;
  logic [XLEN-1:0]    w_pc_q,     w_pc_d;

  // Captured load word for a stalled W instr
  logic               hold_v_q,    hold_v_d;
  logic [XLEN-1:0]    hold_data_q, hold_data_d;

  logic [CNT_W-1:0]   instret_q,   instret_d;

  logic               w_update;
  logic [XLEN-1:0]    load_word;
  logic [XLEN-1:0]    load_val;
  logic [XLEN-1:0]    wb_data;
  logic               wb_we;

  // W is rewritten on any unstalled edge and on flush (flush beats stall).
  assign w_update = flush | ~stall;

  always_comb begin
    w_valid_d  = w_valid_q;
    w_reg_we_d = w_reg_we_q;
    w_rd_d     = w_rd_q;
    w_wb_sel_d = w_wb_sel_q;
    w_funct3_d = w_funct3_q;
    w_alu_d    = w_alu_q;
    w_pc_d     = w_pc_q;

    if (flush) begin
      w_valid_d  = 1'b0;
      w_reg_we_d = 1'b0;
      w_rd_d     = '0;
      w_wb_sel_d = WB_SEL_ALU;
      w_funct3_d = '0;
      w_alu_d    = '0;
      w_pc_d     = '0;
    end else if (!stall) begin
      w_valid_d  = m_valid;
      w_reg_we_d = m_reg_we;
      w_rd_d     = m_rd;
      w_wb_sel_d = m_wb_sel;
      w_funct3_d = m_funct3;
      w_alu_d    = m_alu_result;
      w_pc_d     = m_pc;
    end
  end

  // dmem only presents the word for one cycle, so grab it on the first stalled edge.
  always_comb begin
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    if (w_update) begin
      hold_v_d = 1'b0;
    end else if (w_valid_q && !hold_v_q) begin
      hold_v_d    = 1'b1;
      hold_data_d = dmem_rdata;
    end
  end

  // An instr retires when it leaves W; a stalled one does not, even if flushed.
  always_comb begin
    instret_d = instret_q;
    if (w_valid_q && !stall) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_valid_q   <= 1'b0;
      w_reg_we_q  <= 1'b0;
      w_rd_q      <= '0;
      w_wb_sel_q  <= WB_SEL_ALU;
      w_funct3_q  <= '0;
      w_alu_q     <= '0;
      w_pc_q      <= '0;
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
      instret_q   <= '0;
    end else begin
      w_valid_q   <= w_valid_d;
      w_reg_we_q  <= w_reg_we_d;
      w_rd_q      <= w_rd_d;
      w_wb_sel_q  <= w_wb_sel_d;
      w_funct3_q  <= w_funct3_d;
      w_alu_q     <= w_alu_d;
      w_pc_q      <= w_pc_d;
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      instret_q   <= instret_d;
    end
  end

  assign load_word = hold_v_q ? hold_data_q : dmem_rdata;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .word_i   (load_word),
    .off_i    (w_alu_q[1:0]),
    .funct3_i (w_funct3_q),
    .result_o (load_val)
  );

  always_comb begin
    wb_data = w_alu_q;
    case (w_wb_sel_q)
      WB_SEL_MEM: wb_data = load_val;
      WB_SEL_PC4: wb_data = w_pc_q + XLEN'(4);
      default:    wb_data = w_alu_q;
    endcase
  end

  // x0 is never written; a stalled W keeps writing the same value, which is harmless.
  assign wb_we = w_valid_q & w_reg_we_q & (w_rd_q != '0);

  assign rf_we      = wb_we;
  assign rf_wb_addr = w_rd_q;
  assign rf_wb_data = wb_data;
  assign fwd_valid  = wb_we;
  assign fwd_rd     = w_rd_q;
  assign fwd_data   = wb_data;
  assign instret    = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        m_valid, m_reg_we;
  logic [4:0]  m_rd;
  logic [1:0]  m_wb_sel;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_result, m_pc, dmem_rdata;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_wb_addr, fwd_rd;
  logic [31:0] rf_wb_data, fwd_data;
  logic [63:0] instret;

  int total = 0;
  int bad   = 0;

  // Reference model: the instruction currently sitting in W, and the word it loaded.
  bit          mv;
  logic        mwe;
  logic [4:0]  mrd;
  logic [1:0]  msel;
  logic [2:0]  mf3;
  logic [31:0] malu, mpc, mword;
  logic [63:0] mcnt;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_reg_we     (m_reg_we),
    .m_rd         (m_rd),
    .m_wb_sel     (m_wb_sel),
    .m_funct3     (m_funct3),
    .m_alu_result (m_alu_result),
    .m_pc         (m_pc),
    .dmem_rdata   (dmem_rdata),
    .rf_we        (rf_we),
    .rf_wb_addr   (rf_wb_addr),
    .rf_wb_data   (rf_wb_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .instret      (instret)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Loaded value computed with shifts, masks and two's-complement arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    logic [31:0] v;
    int unsigned off;
    off = addr % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] ref_data();
    case (msel)
      2'd1:    return ref_load(mf3, malu, mword);
      2'd2:    return mpc + 32'd4;
      default: return malu;
    endcase
  endfunction

  task automatic check_model(input string tag);
    logic exp_we;
    exp_we = mv && mwe && (mrd != 5'd0);
    chk({tag, "/we"}, 64'(rf_we), 64'(exp_we));
    chk({tag, "/fwd_v"}, 64'(fwd_valid), 64'(exp_we));
    chk({tag, "/instret"}, instret, mcnt);
    if (mv) begin
      chk({tag, "/addr"}, 64'(rf_wb_addr), 64'(mrd));
      chk({tag, "/data"}, 64'(rf_wb_data), 64'(ref_data()));
      chk({tag, "/fwd_rd"}, 64'(fwd_rd), 64'(mrd));
      chk({tag, "/fwd_data"}, 64'(fwd_data), 64'(ref_data()));
    end
  endtask

  task automatic step(input string tag, input logic st, input logic fl, input logic a_valid,
                      input logic a_we, input logic [4:0] a_rd, input logic [1:0] a_sel,
                      input logic [2:0] a_f3, input logic [31:0] a_alu, input logic [31:0] a_pc,
                      input logic [31:0] dnext);
    bit entered;
    stall = st; flush = fl; m_valid = a_valid; m_reg_we = a_we; m_rd = a_rd;
    m_wb_sel = a_sel; m_funct3 = a_f3; m_alu_result = a_alu; m_pc = a_pc;
    @(posedge clk);
    entered = 1'b0;
    if (!st && mv) mcnt = mcnt + 64'd1;
    if (fl) begin
      mv = 1'b0; mwe = 1'b0; mrd = '0; msel = '0; mf3 = '0; malu = '0; mpc = '0;
    end else if (!st) begin
      mv = a_valid; mwe = a_we; mrd = a_rd; msel = a_sel; mf3 = a_f3; malu = a_alu; mpc = a_pc;
      entered = 1'b1;
    end
    #1;
    dmem_rdata = dnext;
    if (entered) mword = dnext;
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    mv = 1'b0; mwe = 1'b0; mrd = '0; msel = '0; mf3 = '0; malu = '0; mpc = '0; mcnt = '0;
    #1;
    chk({tag, "/we"}, 64'(rf_we), 64'd0);
    chk({tag, "/addr"}, 64'(rf_wb_addr), 64'd0);
    chk({tag, "/data"}, 64'(rf_wb_data), 64'd0);
    chk({tag, "/fwd_v"}, 64'(fwd_valid), 64'd0);
    chk({tag, "/fwd_rd"}, 64'(fwd_rd), 64'd0);
    chk({tag, "/fwd_data"}, 64'(fwd_data), 64'd0);
    chk({tag, "/instret"}, instret, 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] cnt_before;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; m_valid = 1'b0; m_reg_we = 1'b0;
    m_rd = '0; m_wb_sel = '0; m_funct3 = '0; m_alu_result = '0; m_pc = '0;
    dmem_rdata = '0;
    mword = '0;
    @(posedge clk);
    do_reset("reset");

    // ALU write to x5, retires when it leaves W
    step("alu", 0, 0, 1, 1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'h100, 32'h0);
    chk("alu_data", 64'(rf_wb_data), 64'h1234);
    chk("alu_addr", 64'(rf_wb_addr), 64'd5);
    chk("alu_cnt0", instret, 64'd0);
    // x0 destination: no write, but still retires
    step("x0", 0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 32'hFFFF, 32'h104, 32'h0);
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("alu_cnt1", instret, 64'd1);

    // Sub-word loads from the same word
    step("lb", 0, 0, 1, 1, 5'd6, 2'd1, 3'd0, 32'h1003, 32'h108, 32'h80FF_0000);
    chk("lb_data", 64'(rf_wb_data), 64'hFFFF_FF80);
    chk("x0_cnt", instret, 64'd2);
    step("lbu", 0, 0, 1, 1, 5'd6, 2'd1, 3'd4, 32'h1003, 32'h10C, 32'h80FF_0000);
    chk("lbu_data", 64'(rf_wb_data), 64'h0000_0080);
    step("lh", 0, 0, 1, 1, 5'd6, 2'd1, 3'd1, 32'h1002, 32'h110, 32'h80FF_0000);
    chk("lh_data", 64'(rf_wb_data), 64'hFFFF_80FF);
    step("lhu", 0, 0, 1, 1, 5'd6, 2'd1, 3'd5, 32'h1002, 32'h114, 32'h80FF_0000);
    chk("lhu_data", 64'(rf_wb_data), 64'h0000_80FF);

    // LW held by a 3-cycle stall while dmem moves on
    step("lw", 0, 0, 1, 1, 5'd7, 2'd1, 3'd2, 32'h2000, 32'h118, 32'hCAFE_F00D);
    cnt_before = instret;
    for (int i = 0; i < 3; i++) begin
      step("lw_stall", 1, 0, 1, 1, 5'd9, 2'd0, 3'd0, 32'h5555, 32'h11C, 32'h0000_DEAD);
      chk("lw_hold_data", 64'(rf_wb_data), 64'hCAFE_F00D);
      chk("lw_hold_we", 64'(rf_we), 64'd1);
      chk("lw_hold_cnt", instret, cnt_before);
    end
    step("lw_rel", 0, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    chk("lw_rel_cnt", instret, cnt_before + 64'd1);

    // stall and flush together: W becomes a bubble
    step("pre_sf", 0, 0, 1, 1, 5'd8, 2'd0, 3'd0, 32'h55, 32'h120, 32'h0);
    step("stall_flush", 1, 1, 1, 1, 5'd9, 2'd0, 3'd0, 32'h66, 32'h124, 32'h0);
    chk("sf_we", 64'(rf_we), 64'd0);

    // JAL link value wraps
    step("jal", 0, 0, 1, 1, 5'd1, 2'd2, 3'd0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    chk("jal_data", 64'(rf_wb_data), 64'h0);

    // Reset while a load is stalled in W
    step("lw2", 0, 0, 1, 1, 5'd10, 2'd1, 3'd2, 32'h3000, 32'h200, 32'h1357_9BDF);
    step("lw2_stall", 1, 0, 1, 1, 5'd11, 2'd0, 3'd0, 32'h0, 32'h204, 32'hBAD0_BAD0);
    do_reset("reset_mid");
    stall = 1'b0;
    step("post_reset", 0, 0, 1, 1, 5'd12, 2'd1, 3'd2, 32'h4000, 32'h208, 32'h2468_ACE0);
    step("post_reset_st", 1, 0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h1111_1111);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(3) == 0), ($urandom_range(9) == 0),
           ($urandom_range(7) != 0), 1'($urandom),
           5'($urandom), 2'($urandom), 3'($urandom),
           32'($urandom), 32'($urandom), 32'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
